// File: rtl/cmd_pkt_rx_shk_if.sv
// Byte shake read bus between the UART shake slave and the command receiver.
// The receiver uses the master modport; the byte source uses the slave modport.
interface cmd_pkt_rx_shk_if #(
  parameter int WD_SHK_DATA = 8,
  parameter int WD_SHK_ADDR = 8
) ();
  logic                   valid;
  logic                   msync;
  logic [WD_SHK_DATA-1:0] mdata;
  logic [WD_SHK_ADDR-1:0] maddr;
  logic                   ready;
  logic                   ssync;
  logic [WD_SHK_DATA-1:0] sdata;
  logic [WD_SHK_ADDR-1:0] saddr;

  modport master (
    output valid, msync, mdata, maddr,
    input  ready, ssync, sdata, saddr
  );

  modport slave (
    input  valid, msync, mdata, maddr,
    output ready, ssync, sdata, saddr
  );
endinterface

// File: rtl/cmd_pkt_rx_shk.sv
// Command packet receiver: hunts a start word, reads length + payload + XOR checksum, commits atomically.
// Define CMD_PKT_RX_TIMEOUT_EN to build the inter-byte timeout that aborts a stalled packet.
module cmd_pkt_rx_shk #(
  parameter logic [31:0] MD_CMD_START  = 32'h1331_0001,
  parameter int          MD_MSB_FIRST  = 0,
  parameter int          NB_CMD_ORDE   = 128,
  parameter int          WD_CMD_DATA   = 32,
  parameter int          WD_SHK_DATA   = 8,
  parameter int          WD_SHK_ADDR   = 8,
  parameter int          WD_SLEEP_SPAN = 24,
  parameter int          WD_ERR_INFO   = 4
) (
  input  logic                                i_sys_clk,
  input  logic                                i_sys_resetn,
  cmd_pkt_rx_shk_if.master                    m_shk_rd,
  output logic [WD_CMD_DATA*NB_CMD_ORDE-1:0]  m_cmd_dst_arry,
  output logic                                m_cmd_dst_vld,
  output logic [$clog2(NB_CMD_ORDE+1)-1:0]    m_cmd_dst_len,
  output logic [WD_ERR_INFO-1:0]              m_err_cmd_info1
);

  localparam int NB_CMD_BYTE = WD_CMD_DATA / WD_SHK_DATA;
  localparam int LW = $clog2(NB_CMD_ORDE + 1);
  localparam int AW = (NB_CMD_ORDE > 1) ? $clog2(NB_CMD_ORDE) : 1;
  localparam int BW = (NB_CMD_BYTE > 1) ? $clog2(NB_CMD_BYTE) : 1;
  localparam logic [WD_CMD_DATA-1:0] START_WORD = WD_CMD_DATA'(MD_CMD_START);

  typedef enum logic [1:0] {S_HUNT, S_LEN, S_DATA, S_CHK} state_t;

  state_t                 state_q, state_d;
  logic                   r_ready;
  logic                   byte_stb;
  logic [WD_CMD_DATA-1:0] win_q, win_d, win_lsb, win_msb;
  logic [BW-1:0]          cnt_q;
  logic                   word_vld;
  logic [LW-1:0]          len_q, idx_q;
  logic [WD_CMD_DATA-1:0] xor_q;
  logic [WD_CMD_DATA-1:0] shadow [NB_CMD_ORDE];
  logic [WD_CMD_DATA-1:0] arry   [NB_CMD_ORDE];
  logic [WD_ERR_INFO-1:0] err_q, err_d;
  logic                   valid_q;
  logic                   timeout;
  logic                   len_bad, chk_bad, commit, abort;
  logic                   unused_ok;

  assign byte_stb = m_shk_rd.ready & ~r_ready;

  // New byte enters at the top (LSB-first) or at the bottom (MSB-first) of the word window.
  assign win_lsb = WD_CMD_DATA'({m_shk_rd.sdata, win_q} >> WD_SHK_DATA);
  assign win_msb = WD_CMD_DATA'({win_q, m_shk_rd.sdata});
  assign win_d   = (MD_MSB_FIRST != 0) ? win_msb : win_lsb;

`ifdef CMD_PKT_RX_TIMEOUT_EN
  logic [WD_SLEEP_SPAN-1:0] idle_q;

  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn)                   idle_q <= '0;
    else if (byte_stb)                   idle_q <= '0;
    else if (!idle_q[WD_SLEEP_SPAN-1])   idle_q <= idle_q + 1'b1;
  end

  assign timeout = idle_q[WD_SLEEP_SPAN-1];
`else
  localparam int UNUSED_SLEEP_SPAN = WD_SLEEP_SPAN;
  assign timeout = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    len_bad = 1'b0;
    chk_bad = 1'b0;
    commit  = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      S_HUNT: if (byte_stb && win_d == START_WORD) state_d = S_LEN;
      S_LEN: begin
        if (word_vld) begin
          len_bad = (win_q == '0) || (win_q > WD_CMD_DATA'(NB_CMD_ORDE));
          state_d = len_bad ? S_HUNT : S_DATA;
        end
      end
      S_DATA: if (word_vld && idx_q == len_q - 1'b1) state_d = S_CHK;
      S_CHK: begin
        if (word_vld) begin
          commit  = (win_q == xor_q);
          chk_bad = ~commit;
          state_d = S_HUNT;
        end
      end
      default: state_d = S_HUNT;
    endcase
    if (timeout && state_q != S_HUNT) begin
      abort   = 1'b1;
      commit  = 1'b0;
      chk_bad = 1'b0;
      len_bad = 1'b0;
      state_d = S_HUNT;
    end

    err_d = err_q;
    if (commit)            err_d = '0;
    if (commit & byte_stb) err_d[3] = 1'b1;
    if (len_bad)           err_d[1] = 1'b1;
    if (chk_bad)           err_d[2] = 1'b1;
    if (abort)             err_d[0] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      state_q  <= S_HUNT;
      r_ready  <= 1'b0;
      valid_q  <= 1'b0;
      win_q    <= '0;
      cnt_q    <= '0;
      word_vld <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      r_ready  <= m_shk_rd.ready;
      valid_q  <= 1'b1;
      err_q    <= err_d;
      if (byte_stb) win_q <= win_d;
      word_vld <= byte_stb && state_q != S_HUNT && cnt_q == BW'(NB_CMD_BYTE - 1);
      if (state_d != state_q)
        cnt_q <= '0;
      else if (byte_stb && state_q != S_HUNT)
        cnt_q <= (cnt_q == BW'(NB_CMD_BYTE - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: the shadow buffer and command array are reset explicitly because the
  // consumers must see all-zero commands out of reset.
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      len_q         <= '0;
      idx_q         <= '0;
      xor_q         <= '0;
      m_cmd_dst_vld <= 1'b0;
      m_cmd_dst_len <= '0;
      for (int j = 0; j < NB_CMD_ORDE; j++) begin
        shadow[j] <= '0;
        arry[j]   <= '0;
      end
    end else begin
      m_cmd_dst_vld <= commit;
      if (state_q == S_LEN && word_vld) begin
        len_q <= LW'(win_q);
        xor_q <= win_q;
        idx_q <= '0;
      end
      if (state_q == S_DATA && word_vld) begin
        shadow[idx_q[AW-1:0]] <= win_q;
        xor_q <= xor_q ^ win_q;
        idx_q <= idx_q + 1'b1;
      end
      if (commit) begin
        m_cmd_dst_len <= len_q;
        for (int j = 0; j < NB_CMD_ORDE; j++)
          if (LW'(j) < len_q) arry[j] <= shadow[j];
      end
    end
  end

  for (genvar j = 0; j < NB_CMD_ORDE; j++) begin : g_out
    assign m_cmd_dst_arry[WD_CMD_DATA*j +: WD_CMD_DATA] = arry[j];
  end

  assign m_shk_rd.valid  = valid_q;
  assign m_shk_rd.msync  = (state_q == S_DATA);
  assign m_shk_rd.mdata  = '0;
  assign m_shk_rd.maddr  = WD_SHK_ADDR'(idx_q);
  assign m_err_cmd_info1 = err_q;
  assign unused_ok       = ^{m_shk_rd.ssync, m_shk_rd.saddr};

endmodule

// File: doc/cmd_pkt_rx_shk.md
Name: cmd_pkt_rx_shk

Overview:
Second-generation command receiver on the byte shake bus (UART side).
- Hunts a configurable start word and reads a length-prefixed packet of command words.
- Checks the packet against an XOR checksum.
- Commits the payload atomically into a parametrised command array and pulses an update strobe.
- Reports timeout, length and checksum errors.
- Sits between the uart shake slave and the command/register consumers.

Parameters:
MD_CMD_START, 32'h1331_0001, start-of-packet word (compared at WD_CMD_DATA bits).
MD_MSB_FIRST, 0, 0 = first byte of a word lands in the LSB; 1 = first byte lands in the MSB.
NB_CMD_ORDE, 128, depth of the command array, in words.
WD_CMD_DATA, 32, command word width; must be a multiple of WD_SHK_DATA.
WD_SHK_DATA, 8, shake data width.
WD_SHK_ADDR, 8, shake address width.
WD_SLEEP_SPAN, 24, inter-byte timeout is 2^(WD_SLEEP_SPAN-1) clocks; used only with the option.
WD_ERR_INFO, 4, error field width; must be at least 4.

Ports:
i_sys_clk  in  1  system clock.
i_sys_resetn  in  1  reset, asynchronous, active-low.
m_shk_rd_valid  out  1  1 when the receiver is armed.
m_shk_rd_msync  out  1  1 in the DATA state.
m_shk_rd_mdata  out  WD_SHK_DATA  constant 0.
m_shk_rd_maddr  out  WD_SHK_ADDR  low bits of the payload word index.
m_shk_rd_ready  in  1  byte strobe; its rising edge means a new byte.
m_shk_rd_ssync  in  1  unused.
m_shk_rd_sdata  in  WD_SHK_DATA  received byte.
m_shk_rd_saddr  in  WD_SHK_ADDR  unused.
m_cmd_dst_arry  out  WD_CMD_DATA*NB_CMD_ORDE  committed command words; word j sits at bits [WD_CMD_DATA*(j+1)-1 : WD_CMD_DATA*j].
m_cmd_dst_vld  out  1  one-cycle pulse on commit.
m_cmd_dst_len  out  clog2(NB_CMD_ORDE+1)  word count of the last committed packet.
m_err_cmd_info1  out  WD_ERR_INFO  sticky error bits.

Behaviour:
Reset (asynchronous assert, synchronous release):
- All outputs, the array, the shadow buffer and all counters go to 0; state = HUNT.
- m_shk_rd_valid = 1 from the first clock after release.

Byte strobe:
- byte_stb = m_shk_rd_ready & ~r_ready, where r_ready is m_shk_rd_ready registered.
- A level held high produces exactly one strobe.

Word assembly:
- Shift register of NB_CMD_BYTE = WD_CMD_DATA/WD_SHK_DATA bytes, shifted on each byte_stb.
- MD_MSB_FIRST=0: new byte enters the top and older bytes shift down. MD_MSB_FIRST=1: new byte enters the bottom.
- A byte counter wraps at NB_CMD_BYTE-1 and is reset to 0 on every state change.
- word_vld is registered: it goes high the cycle after the strobe that completes a word.

State machine:
- HUNT: compare the window to MD_CMD_START on every byte_stb; the counter is not used. On match -> LEN with the byte counter cleared.
- LEN: on word_vld, capture len and start xor = word.
  - len = 0 or len > NB_CMD_ORDE: set err[1], -> HUNT.
  - Otherwise -> DATA with idx = 0.
- DATA: on word_vld, write shadow[idx] = word, xor ^= word, idx++. When idx reaches len-1 -> CHK.
- CHK: on word_vld:
  - word == xor: copy shadow[0..len-1] into the array in one cycle, pulse m_cmd_dst_vld, latch m_cmd_dst_len = len, clear all err bits.
  - Otherwise set err[2]; the array is unchanged.
  - Either way -> HUNT.

Commit and array rules:
- Latency from the final checksum byte_stb to the array update and vld pulse is 2 clocks.
- Array words at index >= len keep their old values.
- A start pattern inside the payload is treated as data; there is no resync in DATA.
- m_shk_rd_maddr = idx truncated to WD_SHK_ADDR bits.

Error bits:
- err[0]: timeout.
- err[1]: length error.
- err[2]: checksum error.
- err[3]: a byte_stb arrived in the same cycle as a commit. The byte is still accepted by HUNT.
- Error bits are cleared only by reset or a good commit.

Optional Feature:
Macro: CMD_PKT_RX_TIMEOUT_EN.
- Defined:
  - An idle counter clears on byte_stb and otherwise saturates at bit WD_SLEEP_SPAN-1.
  - If that bit sets while in LEN, DATA or CHK: set err[0], drop the partial packet (array untouched), -> HUNT.
  - In HUNT the counter has no effect.
- Undefined:
  - No counter is built, err[0] is tied to 0, and a partial packet waits indefinitely.

Test Plan:
1. Good packet. Defaults, LSB-first. Send bytes 01 00 31 13, len 02 00 00 00, words 01 00 A5 A5 and FF 00 00 00, xor FC 00 A5 A5. Required: array[0]=A5A50001, array[1]=000000FF, vld pulses once 2 clocks after the last strobe, len=2, err=0, array[2..] stay 0.
2. Bad checksum. Same packet with xor byte FD. Required: err=4'b0100, no vld, array unchanged. Then a repeat of the good packet gives err=0 and vld.
3. Bad length. Send start then len 129 (81 00 00 00). Required: err[1]=1, state back to HUNT; a following good packet commits.
4. Hunt alignment. Send junk 13 01 00 31 before the start word, and hold ready high for 5 clocks per byte. Required: exactly one strobe per byte, the start word is found, and test 1 results are reproduced.
5. Timeout (CMD_PKT_RX_TIMEOUT_EN, WD_SLEEP_SPAN=6). Stop after 2 payload bytes for 40 clocks. Required: err[0]=1, array unchanged, next packet commits. Without the macro: no error is raised and the packet completes when the remaining bytes arrive.
6. Reset mid-DATA. Assert reset asynchronously between clock edges. Required: outputs go to 0 immediately; after release the receiver hunts and the next packet commits.
